// File: rtl/implies_operand_loader_if.sv
// Bundle between the serial operand loader and its neighbours: bit-serial input, word output, status.
// LOADER_PARITY_EN adds the sticky parity_err status line.
interface implies_operand_loader_if #(
  parameter int CW = 3
);
  logic          ser_bit;
  logic          ser_stb;
  logic          ser_sof;
  // A word moves on every rising edge where out_valid && out_ready; out_a/out_b are held while out_valid && !out_ready.
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_a;
  logic [3:0]    out_b;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic [1:0]    fsm_state;
`ifdef LOADER_PARITY_EN
  logic          parity_err;

  modport master (
    input  ser_bit, ser_stb, ser_sof, out_ready,
    output out_valid, out_a, out_b, fifo_count, overflow, fsm_state, parity_err
  );
  modport slave (
    output ser_bit, ser_stb, ser_sof, out_ready,
    input  out_valid, out_a, out_b, fifo_count, overflow, fsm_state, parity_err
  );
`else
  modport master (
    input  ser_bit, ser_stb, ser_sof, out_ready,
    output out_valid, out_a, out_b, fifo_count, overflow, fsm_state
  );
  modport slave (
    output ser_bit, ser_stb, ser_sof, out_ready,
    input  out_valid, out_a, out_b, fifo_count, overflow, fsm_state
  );
`endif
endinterface

// File: rtl/implies_operand_loader.sv
// Assembles LSB-first serial frames into {B,A} words and buffers them in a small FIFO for the implies gate.
// LOADER_PARITY_EN: 9-bit frames with an even-parity bit; bad frames are dropped and flagged on parity_err.
module implies_operand_loader #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  implies_operand_loader_if.master bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef LOADER_PARITY_EN
  localparam int FW = 9;
`else
  localparam int FW = 8;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    idx;
  logic [FW-1:0] frame_q, frame_d;
  logic          push;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          out_valid;
  logic          do_pop;
  logic          do_push;
  logic          full;
  logic          drop;

`ifdef LOADER_PARITY_EN
  logic          perr_set;
  logic          parity_err_q;
`endif

  // Frame assembly: a strobe with sof always lands in bit 0, discarding any partial frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    push    = 1'b0;
`ifdef LOADER_PARITY_EN
    perr_set = 1'b0;
`endif
    idx     = bus.ser_sof ? 4'd0 : cnt_q;
    if (bus.ser_stb) begin
      for (int i = 0; i < FW; i++) begin
        if (idx == 4'(i)) frame_d[i] = bus.ser_bit;
      end
      if (idx == 4'(FW - 1)) begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
`ifdef LOADER_PARITY_EN
        if (^frame_d) perr_set = 1'b1;
        else          push     = 1'b1;
`else
        push    = 1'b1;
`endif
      end else begin
        cnt_d = idx + 4'd1;
`ifdef LOADER_PARITY_EN
        state_d = (idx == 4'd7) ? S_PARITY : S_SHIFT;
`else
        state_d = S_SHIFT;
`endif
      end
    end else if (bus.ser_sof) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end
  end

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign out_valid = (count_q != '0);
  assign do_pop    = out_valid && bus.out_ready;
  assign full      = (count_q == CW'(DEPTH));
  assign do_push   = push && (!full || do_pop);
  assign drop      = push && full && !do_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      frame_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
`ifdef LOADER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
`ifdef LOADER_PARITY_EN
      if (perr_set) parity_err_q <= 1'b1;
`endif
    end
  end

  // Storage needs no reset: out_a/out_b are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= frame_d[7:0];
  end

  assign bus.out_valid  = out_valid;
  assign bus.out_a      = out_valid ? mem[rd_ptr_q][3:0] : 4'd0;
  assign bus.out_b      = out_valid ? mem[rd_ptr_q][7:4] : 4'd0;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.fsm_state  = state_q;
`ifdef LOADER_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_implies_operand_loader.sv
// Directed bench for implies_operand_loader: serial frame driver, expected-word queue, summary report.
module tb_implies_operand_loader;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  implies_operand_loader_if #(.CW(CW)) lif ();

  implies_operand_loader #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (lif.master)
  );

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int cmp_n = 0;
  int err_n = 0;
  int pop_n = 0;
  int p0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic sof);
    lif.ser_bit = b;
    lif.ser_stb = 1'b1;
    lif.ser_sof = sof;
    tick();
    lif.ser_stb = 1'b0;
    lif.ser_sof = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w, input logic ready_last, input logic expect_push);
    for (int i = 0; i < 7; i++) send_bit(w[i], 1'b0);
`ifdef LOADER_PARITY_EN
    send_bit(w[7], 1'b0);
    if (ready_last) lif.out_ready = 1'b1;
    send_bit(^w, 1'b0);
`else
    if (ready_last) lif.out_ready = 1'b1;
    send_bit(w[7], 1'b0);
`endif
    if (expect_push) exp_q.push_back(w);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_valid"}, lif.out_valid, 0);
    check({tag, "_a"}, lif.out_a, 0);
    check({tag, "_b"}, lif.out_b, 0);
    check({tag, "_count"}, lif.fifo_count, 0);
    check({tag, "_ovf"}, lif.overflow, 0);
    check({tag, "_state"}, lif.fsm_state, 0);
`ifdef LOADER_PARITY_EN
    check({tag, "_perr"}, lif.parity_err, 0);
`endif
    #1 rst = 1'b0;
    exp_q.delete();
    tick();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (lif.fifo_count !== '0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, lif.fifo_count, 0);
  endtask

  // Scoreboard: every accepted head word must match the oldest expected word.
  always @(negedge clk) begin
    if (rst === 1'b0 && lif.out_valid === 1'b1 && lif.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        cmp_n++;
        err_n++;
        $error("FAIL unexpected_word: observed %02h required none", {lif.out_b, lif.out_a});
      end else begin
        mon_exp = exp_q.pop_front();
        pop_n++;
        cmp_n++;
        assert ({lif.out_b, lif.out_a} === mon_exp) else begin
          err_n++;
          $error("FAIL word: observed %02h required %02h", {lif.out_b, lif.out_a}, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    rst           = 1'b1;
    lif.ser_bit   = 1'b0;
    lif.ser_stb   = 1'b0;
    lif.ser_sof   = 1'b0;
    lif.out_ready = 1'b0;
    #1;
    check("rst_valid", lif.out_valid, 0);
    check("rst_a", lif.out_a, 0);
    check("rst_b", lif.out_b, 0);
    check("rst_count", lif.fifo_count, 0);
    check("rst_ovf", lif.overflow, 0);
    #11 rst = 1'b0;
    tick();

    // Single frame 0xB5 with ready held high: one cycle of valid.
    lif.out_ready = 1'b1;
    send_frame(8'hB5, 1'b0, 1'b1);
    check("t1_valid", lif.out_valid, 1);
    check("t1_a", lif.out_a, 4'h5);
    check("t1_b", lif.out_b, 4'hB);
    tick();
    check("t1_valid_off", lif.out_valid, 0);
    check("t1_count", lif.fifo_count, 0);
    check("t1_pops", pop_n, 1);

    // No strobe holds a partial frame; sof without strobe abandons it.
    lif.out_ready = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    repeat (5) tick();
    check("hold_state", lif.fsm_state, 1);
    lif.ser_sof = 1'b1;
    tick();
    lif.ser_sof = 1'b0;
    check("sof_idle_state", lif.fsm_state, 0);
    check("sof_idle_count", lif.fifo_count, 0);

    // Backpressure then overflow on the fifth frame.
    send_frame(8'h10, 1'b0, 1'b1);
    send_frame(8'h21, 1'b0, 1'b1);
    send_frame(8'h32, 1'b0, 1'b1);
    send_frame(8'h43, 1'b0, 1'b1);
    check("t3_ovf_before", lif.overflow, 0);
    send_frame(8'h54, 1'b0, 1'b0);
    check("t3_count", lif.fifo_count, 4);
    check("t3_ovf", lif.overflow, 1);
    check("t3_head_a", lif.out_a, 4'h0);
    check("t3_head_b", lif.out_b, 4'h1);
    repeat (3) tick();
    check("t3_held_a", lif.out_a, 4'h0);
    check("t3_held_b", lif.out_b, 4'h1);
    p0 = pop_n;
    lif.out_ready = 1'b1;
    wait_drain("t3", 20);
    repeat (3) tick();
    check("t3_pops", pop_n - p0, 4);
    check("t3_left", exp_q.size(), 0);
    check("t3_valid_off", lif.out_valid, 0);
    check("t3_ovf_sticky", lif.overflow, 1);
    pulse_reset("rst2");

    // Full FIFO with a pop on the edge completing the next frame.
    lif.out_ready = 1'b0;
    send_frame(8'h10, 1'b0, 1'b1);
    send_frame(8'h21, 1'b0, 1'b1);
    send_frame(8'h32, 1'b0, 1'b1);
    send_frame(8'h43, 1'b0, 1'b1);
    check("t4_full", lif.fifo_count, 4);
    p0 = pop_n;
    send_frame(8'h54, 1'b1, 1'b1);
    check("t4_count", lif.fifo_count, 4);
    check("t4_ovf", lif.overflow, 0);
    wait_drain("t4", 20);
    repeat (2) tick();
    check("t4_pops", pop_n - p0, 5);
    check("t4_left", exp_q.size(), 0);

    // Resync: three stray bits, then sof restarts the frame 0x0F.
    lif.out_ready = 1'b1;
    p0 = pop_n;
    w = 8'h0F;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(w[0], 1'b1);
    for (int i = 1; i < 8; i++) send_bit(w[i], 1'b0);
`ifdef LOADER_PARITY_EN
    send_bit(^w, 1'b0);
`endif
    exp_q.push_back(w);
    repeat (4) tick();
    check("t5_pops", pop_n - p0, 1);
    check("t5_left", exp_q.size(), 0);

    // Asynchronous reset with two buffered words and a partial frame.
    lif.out_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b1);
    check("t6_count", lif.fifo_count, 2);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    pulse_reset("t6_rst");
    p0 = pop_n;
    send_frame(8'hC3, 1'b1, 1'b1);
    check("t6_valid", lif.out_valid, 1);
    check("t6_a", lif.out_a, 4'h3);
    check("t6_b", lif.out_b, 4'hC);
    repeat (3) tick();
    check("t6_pops", pop_n - p0, 1);
    check("t6_left", exp_q.size(), 0);

`ifdef LOADER_PARITY_EN
    // Bad parity is dropped and flagged; good parity is accepted.
    lif.out_ready = 1'b0;
    w = 8'hB5;
    for (int i = 0; i < 8; i++) send_bit(w[i], 1'b0);
    send_bit(1'b0, 1'b0);
    check("par_err", lif.parity_err, 1);
    check("par_count0", lif.fifo_count, 0);
    send_frame(8'hB5, 1'b0, 1'b1);
    check("par_count1", lif.fifo_count, 1);
    check("par_a", lif.out_a, 4'h5);
    check("par_b", lif.out_b, 4'hB);
    lif.out_ready = 1'b1;
    wait_drain("par", 10);
    check("par_err_sticky", lif.parity_err, 1);
`endif

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
